// File: rtl/prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem -- single-port program memory with a fetch port and a bulk loader.
//
// Purpose
//   Holds D = 2**ADDR_W words of W = OP_W+ARG_W bits. A fetch reads one word
//   with a latency of one cycle. A load writes load_len consecutive words
//   starting at load_base, wrapping modulo D, through a valid/ready handshake.
//   Fetches are serviced only while the loader is idle.
//
// Handshake (load port)
//   A word is transferred on every rising edge where load_valid=1 and
//   load_ready=1. load_ready is high for the whole LOAD state and low
//   otherwise, so the producer may present data at any pace; load_data is
//   only sampled on transfer cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_req/addr    read request and word address (taken only in IDLE)
//   fetch_valid       one-cycle qualifier for fetch_op/fetch_arg
//   fetch_op/arg      upper OP_W / lower ARG_W bits of the read word; held
//                     at the last read value while fetch_valid=0
//   load_start/base/len  start a load (taken only in IDLE)
//   load_valid/data/ready  write-data handshake
//   load_busy         high in LOAD and DONE
//   load_done         one-cycle pulse in DONE
//   par_err           (PROG_MEM_PARITY_EN only) parity mismatch on the word
//                     presented with fetch_valid
//   dbg_state         current FSM state (0=IDLE, 1=LOAD, 2=DONE)
//
// Configuration
//   PROG_MEM_PARITY_EN  when defined, stores an even-parity bit per word and
//                       adds the par_err output. Undefined by default.
// ---------------------------------------------------------------------------
module prog_mem #(
    parameter int OP_W   = 4,
    parameter int ARG_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic                  fetch_valid,
    output logic [OP_W-1:0]       fetch_op,
    output logic [ARG_W-1:0]      fetch_arg,
    input  logic                  load_start,
    input  logic [ADDR_W-1:0]     load_base,
    input  logic [ADDR_W:0]       load_len,
    input  logic                  load_valid,
    input  logic [OP_W+ARG_W-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
`ifdef PROG_MEM_PARITY_EN
    output logic                  par_err,
`endif
    output logic [1:0]            dbg_state
);

    localparam int W = OP_W + ARG_W;
    localparam int D = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_fetch_valid;
    logic [W-1:0]      r_fetch_word;
    logic [W-1:0]      r_mem [0:D-1];

    logic              w_fetch_acc;
    logic              w_wr_en;

    // Fetches are only serviced while the loader is idle; this also keeps
    // reads and writes from ever touching the array in the same cycle.
    assign w_fetch_acc = fetch_req && (r_state == ST_IDLE);
    assign w_wr_en     = (r_state == ST_LOAD) && load_valid;

    // -----------------------------------------------------------------------
    // Loader FSM: pointer and remaining-count bookkeeping
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_ptr <= load_base;
                        r_cnt <= load_len;
                        // A zero-length load still reports completion.
                        r_state <= (load_len != '0) ? ST_LOAD : ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        // Pointer is ADDR_W bits wide, so D-1 rolls to 0 and
                        // loads longer than D overwrite their own early words.
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == {{ADDR_W{1'b0}}, 1'b1}) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage array: deliberately not reset so contents survive a reset
    // that interrupts a load.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_ptr] <= load_data;
        end
    end

`ifdef PROG_MEM_PARITY_EN
    logic r_par [0:D-1];
    logic r_par_err;
    logic w_par_bad;

    // Even parity: the stored bit makes the total count of ones even.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_par[r_ptr] <= ^load_data;
        end
    end

    assign w_par_bad = (^r_mem[fetch_addr]) ^ r_par[fetch_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            // Only meaningful alongside fetch_valid, zero otherwise.
            r_par_err <= w_fetch_acc && w_par_bad;
        end
    end

    assign par_err = r_par_err;
`endif

    // -----------------------------------------------------------------------
    // Fetch path: one-cycle latency, data held between reads
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_word  <= '0;
        end else begin
            r_fetch_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_fetch_word <= r_mem[fetch_addr];
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_op    = r_fetch_word[W-1:ARG_W];
    assign fetch_arg   = r_fetch_word[ARG_W-1:0];

    assign load_ready  = (r_state == ST_LOAD);
    assign load_busy   = (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign load_done   = (r_state == ST_DONE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_prog_mem.sv
// ---------------------------------------------------------------------------
// tb_prog_mem -- directed bench for prog_mem with a fetch scoreboard.
// Expected read words are queued when a fetch is issued; a monitor on the
// falling edge pops and compares whenever fetch_valid is high.
// ---------------------------------------------------------------------------
module tb_prog_mem;

    localparam int OP_W   = 4;
    localparam int ARG_W  = 8;
    localparam int ADDR_W = 8;
    localparam int W      = OP_W + ARG_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_valid;
    logic [OP_W-1:0]   fetch_op;
    logic [ARG_W-1:0]  fetch_arg;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] load_base = '0;
    logic [ADDR_W:0]   load_len = '0;
    logic              load_valid = 1'b0;
    logic [W-1:0]      load_data = '0;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;
    logic [1:0]        dbg_state;
`ifdef PROG_MEM_PARITY_EN
    logic              par_err;
`endif

    prog_mem #(.OP_W(OP_W), .ARG_W(ARG_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_op    (fetch_op),
        .fetch_arg   (fetch_arg),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_len    (load_len),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
`ifdef PROG_MEM_PARITY_EN
        .par_err     (par_err),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];
`ifdef PROG_MEM_PARITY_EN
    logic par_q[$];
`endif
    logic [W-1:0] load_buf [0:511];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fetch_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_fetch: got 0x%0h, expected no fetch_valid", {fetch_op, fetch_arg});
            end else begin
                check("fetch_word", {20'd0, fetch_op, fetch_arg}, {20'd0, exp_q.pop_front()});
`ifdef PROG_MEM_PARITY_EN
                check("par_err", {31'd0, par_err}, {31'd0, par_q.pop_front()});
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] word, input logic perr);
        exp_q.push_back(word);
`ifdef PROG_MEM_PARITY_EN
        par_q.push_back(perr);
`else
        if (perr) $display("note: parity expectation ignored");
`endif
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] addr, input logic [W-1:0] word, input logic perr);
        push_exp(word, perr);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req = 1'b0;
        tick();
    endtask

    // Loads load_buf[0..len-1]; gap inserts an idle cycle between words.
    // Any fetch_req set by the caller is dropped after the start cycle.
    task automatic do_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len, input bit gap);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        if (len == 0) begin
            check("len0_busy", {31'd0, load_busy}, 32'd1);
            check("len0_done", {31'd0, load_done}, 32'd1);
            check("len0_ready", {31'd0, load_ready}, 32'd0);
            check("len0_state", {30'd0, dbg_state}, 32'd2);
            tick();
            check("len0_busy_after", {31'd0, load_busy}, 32'd0);
            check("len0_done_after", {31'd0, load_done}, 32'd0);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                load_valid = 1'b1;
                load_data  = load_buf[i];
                check("load_ready", {31'd0, load_ready}, 32'd1);
                check("load_done_early", {31'd0, load_done}, 32'd0);
                tick();
                if (gap && (i != int'(len) - 1)) begin
                    load_valid = 1'b0;
                    load_data  = 12'hFFF;
                    check("gap_ready", {31'd0, load_ready}, 32'd1);
                    check("gap_done", {31'd0, load_done}, 32'd0);
                    tick();
                end
            end
            load_valid = 1'b0;
            check("load_done", {31'd0, load_done}, 32'd1);
            check("done_busy", {31'd0, load_busy}, 32'd1);
            check("done_ready", {31'd0, load_ready}, 32'd0);
            tick();
            check("done_pulse_end", {31'd0, load_done}, 32'd0);
            check("idle_busy", {31'd0, load_busy}, 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #1;
        tick();
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_word", {20'd0, fetch_op, fetch_arg}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_load_busy", {31'd0, load_busy}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Contiguous load of three words at base 0
        load_buf[0] = 12'hC02;
        load_buf[1] = 12'h102;
        load_buf[2] = 12'h600;
        do_load(8'h00, 9'd3, 1'b0);
        do_fetch(8'h01, 12'h102, 1'b0);
        do_fetch(8'h00, 12'hC02, 1'b0);
        do_fetch(8'h02, 12'h600, 1'b0);
        check("hold_after_read", {20'd0, fetch_op, fetch_arg}, 32'h600);

        // Gapped producer
        load_buf[0] = 12'h345;
        load_buf[1] = 12'h9AB;
        do_load(8'h10, 9'd2, 1'b1);
        do_fetch(8'h11, 12'h9AB, 1'b0);
        do_fetch(8'h10, 12'h345, 1'b0);

        // Pointer wrap from 0xFF to 0x00
        load_buf[0] = 12'hA11;
        load_buf[1] = 12'hB22;
        do_load(8'hFF, 9'd2, 1'b0);
        do_fetch(8'hFF, 12'hA11, 1'b0);
        do_fetch(8'h00, 12'hB22, 1'b0);
        do_fetch(8'h01, 12'h102, 1'b0);

        // Zero-length load with a fetch in the start cycle
        push_exp(12'h345, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = 8'h10;
        do_load(8'h01, 9'd0, 1'b0);
        do_fetch(8'h01, 12'h102, 1'b0);

        // Fetch in the start cycle of a real load sees pre-load contents
        push_exp(12'h9AB, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = 8'h11;
        load_buf[0] = 12'h777;
        do_load(8'h11, 9'd1, 1'b0);
        do_fetch(8'h11, 12'h777, 1'b0);

        // Fetch ignored during LOAD, load_start ignored, reset mid-load
        load_start = 1'b1;
        load_base  = 8'h20;
        load_len   = 9'd4;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = (i == 0) ? 12'h111 : 12'h222;
            // Restart attempt that must not move the pointer
            load_start = 1'b1;
            load_base  = 8'h50;
            load_len   = 9'd1;
            tick();
            check("fetch_blocked", {31'd0, fetch_valid}, 32'd0);
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        check("midload_state", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, load_busy}, 32'd0);
        check("abort_ready", {31'd0, load_ready}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", {31'd0, load_done}, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("post_abort_done", {31'd0, load_done}, 32'd0);
        do_fetch(8'h20, 12'h111, 1'b0);
        do_fetch(8'h21, 12'h222, 1'b0);
        do_fetch(8'h00, 12'hB22, 1'b0);

        // Load longer than the array: last write wins
        for (int i = 0; i < 257; i++) begin
            load_buf[i] = 12'(i * 3 + 5);
        end
        do_load(8'h30, 9'd257, 1'b0);
        do_fetch(8'h30, 12'h305, 1'b0);
        do_fetch(8'h31, 12'h008, 1'b0);
        do_fetch(8'h2F, 12'h302, 1'b0);

`ifdef PROG_MEM_PARITY_EN
        // Word at 0x05 came from index 213 of the long load: 213*3+5 = 0x284
        do_fetch(8'h05, 12'h284, 1'b0);
        dut.r_par[5] = ~dut.r_par[5];
        do_fetch(8'h05, 12'h284, 1'b1);
        check("par_err_idle", {31'd0, par_err}, 32'd0);
`endif

        repeat (3) tick();
        check("fetch_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode field width.
REQ-002 SHALL have parameter ARG_W, default 8, operand field width; word width W = OP_W+ARG_W.
REQ-003 SHALL have parameter ADDR_W, default 8, address width; depth D = 2**ADDR_W.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports fetch_req  in  1  and fetch_addr  in  ADDR_W: read request and word address.
REQ-007 SHALL have ports fetch_valid  out  1, fetch_op  out  OP_W and fetch_arg  out  ARG_W: read-data qualifier, word[W-1:ARG_W] and word[ARG_W-1:0].
REQ-008 SHALL have ports load_start  in  1, load_base  in  ADDR_W and load_len  in  ADDR_W+1: begin a load of load_len words at load_base.
REQ-009 SHALL have ports load_valid  in  1, load_data  in  W and load_ready  out  1: write-data handshake.
REQ-010 SHALL have ports load_busy  out  1 and load_done  out  1: load in progress, and one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, DONE; load_busy=1 in LOAD and DONE only.
REQ-012 SHALL accept fetch_req only in IDLE; an accepted read SHALL register mem[fetch_addr] and assert fetch_valid for exactly the next cycle (latency 1).
REQ-013 SHALL hold fetch_op/fetch_arg at the last read value while fetch_valid=0.
REQ-014 SHALL ignore fetch_req in LOAD/DONE (no read, fetch_valid=0 next cycle).
REQ-015 SHALL, in IDLE with load_start=1, capture load_base as write pointer and load_len as remaining count; next state LOAD if load_len>0, else DONE with no writes.
REQ-016 SHALL accept fetch_req and load_start in the same IDLE cycle: the read returns pre-load contents next cycle and the load proceeds.
REQ-017 SHALL drive load_ready=1 throughout LOAD, 0 otherwise.
REQ-018 SHALL, per LOAD cycle with load_valid=1, write load_data to mem[pointer], increment pointer modulo D (D-1 wraps to 0) and decrement count.
REQ-019 SHALL go LOAD->DONE on the cycle the final word is written; DONE SHALL assert load_done for one cycle then return to IDLE.
REQ-020 SHALL ignore load_start outside IDLE.
REQ-021 SHALL treat load_len > D as wrapping writes that overwrite earlier words of the same load; the last write wins.
REQ-022 SHALL NOT initialise memory contents; words never written read as undefined.

Reset
REQ-023 SHALL on rst_n=0 force IDLE immediately: fetch_valid=0, fetch_op=0, fetch_arg=0, load_ready=0, load_busy=0, load_done=0, pointer=0, count=0.
REQ-024 SHALL, on reset mid-load, retain all words already written, abort the remainder and emit no load_done pulse.

Configuration
REQ-025 SHALL, with macro PROG_MEM_PARITY_EN defined, store one even-parity bit per word computed from load_data at write time.
REQ-026 SHALL, with PROG_MEM_PARITY_EN, add port par_err  out  1, asserted alongside fetch_valid when recomputed parity of the read word mismatches the stored bit; reset value 0; 0 whenever fetch_valid=0.
REQ-027 SHALL, without PROG_MEM_PARITY_EN, store W bits per word and omit par_err.

Verification
REQ-028 SHALL cover load at base 0, len 3, words 0xC02,0x102,0x600 with load_valid=1 continuously -> load_ready 3 cycles, load_done one cycle later; fetch 1 -> fetch_op=1, fetch_arg=0x02.
REQ-029 SHALL cover load_valid gapped 1-on/1-off, base 0x10, len 2 -> only valid cycles write, load_done after the 2nd write, fetch 0x11 returns the 2nd word.
REQ-030 SHALL cover base 0xFF, len 2, words 0xA11,0xB22 -> mem[0xFF]=0xA11, mem[0x00]=0xB22.
REQ-031 SHALL cover load_len=0 -> load_busy 1 cycle, load_done pulse, no memory change; simultaneous fetch_req in the start cycle returns old data.
REQ-032 SHALL cover fetch_req during LOAD -> fetch_valid stays 0; rst_n low after 2 of 4 words -> IDLE, words 0-1 readable, no load_done.
REQ-033 SHALL cover, with PROG_MEM_PARITY_EN, clean read -> par_err=0; stored parity bit forced inverted at 0x05 -> read of 0x05 gives par_err=1 with fetch_valid.
